core_input_dispatch: RTL and testbench
======================================

CORE_INPUT_DISPATCH -- requirements
Module: core_input_dispatch

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of cores driven (range 1..32).
REQ-002 SHALL have parameter DIN_WIDTH, default 8: core input word width.
REQ-003 SHALL have parameter MAX_WORDS, default 16: maximum words per packet.
REQ-004 SHALL have parameter HOLDOFF, default 3: cycles a core stays ineligible after receiving a packet's last word (range 1..7).
REQ-005 SHALL have port CORE_CLK  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_data  input  DIN_WIDTH  upstream word.
REQ-008 SHALL have port in_addr  input  3  upstream word address.
REQ-009 SHALL have port in_last  input  1  marks the final word of a packet.
REQ-010 SHALL have port in_valid  input  1  upstream word valid.
REQ-011 SHALL have port in_ready  output  1  word accepted when in_valid and in_ready are both high.
REQ-012 SHALL have port crypt_ready  input  N_CORES  per-core ready for new data.
REQ-013 SHALL have port core_idle  input  N_CORES  per-core idle.
REQ-014 SHALL have port err_core  input  N_CORES  per-core error.
REQ-015 SHALL have port din  output  DIN_WIDTH  registered broadcast word to cores.
REQ-016 SHALL have port addr_in  output  3  registered broadcast address.
REQ-017 SHALL have port wr_en  output  N_CORES  registered one-hot write strobe.
REQ-018 SHALL have port all_idle  output  1  no dispatch in progress and all unmasked cores idle.
REQ-019 SHALL have port err_pkt  output  1  sticky packet-overlength error.

Function
REQ-020 SHALL implement FSM states SELECT, SEND, ERROR.
REQ-021 SHALL treat core i as eligible iff crypt_ready[i]=1, holdoff[i]=0 and err_mask[i]=0.
REQ-022 SHALL set err_mask[i] when err_core[i]=1; the mask is cleared only by reset, and masked cores are never selected.
REQ-023 In SELECT with in_valid=1 and at least one eligible core, SHALL latch sel = the first eligible index at or after rr_ptr (wrapping modulo N_CORES) and enter SEND on the next cycle.
REQ-024 In SELECT, in_ready SHALL be 0; with no eligible core, SHALL remain in SELECT.
REQ-025 In SEND, in_ready SHALL be 1; on each accepted word, the next cycle SHALL show din=in_data, addr_in=in_addr and wr_en=one-hot(sel) for exactly that cycle.
REQ-026 wr_en SHALL be 0 in every cycle not following an accepted word (one-cycle latency, no bubbles inserted).
REQ-027 On an accepted word with in_last=1, SHALL load holdoff[sel]=HOLDOFF, set rr_ptr=(sel+1) mod N_CORES and return to SELECT.
REQ-028 crypt_ready[sel] falling during SEND SHALL NOT abort the packet.
REQ-029 SHALL count accepted words per packet; acceptance of word MAX_WORDS+1 without in_last SHALL NOT be forwarded (wr_en stays 0), and SHALL set err_pkt=1 and enter ERROR.
REQ-030 ERROR is terminal until reset: in_ready=0, wr_en=0.
REQ-031 Each nonzero holdoff[i] SHALL decrement by 1 per cycle.
REQ-032 all_idle SHALL be 1 iff state=SELECT, in_valid=0, wr_en=0 and core_idle[i]=1 for every core with err_mask[i]=0.
REQ-033 din and addr_in SHALL hold their last value when wr_en=0.

Reset
REQ-034 While rst=1 (asynchronously), SHALL force state=SELECT, rr_ptr=0, all holdoff=0, err_mask=0, word count=0, din=0, addr_in=0, wr_en=0, in_ready=0 and err_pkt=0.
REQ-035 Reset asserted mid-packet SHALL discard the packet, with no further wr_en after reset.

Verification
REQ-036 N_CORES=4, all crypt_ready=1, three 2-word packets -> wr_en sequence 0001,0001,0010,0010,0100,0100, with din/addr_in matching the inputs one cycle later.
REQ-037 crypt_ready=1010, rr_ptr=0 -> first packet to core 1, second to core 3, third to core 1 only after its holdoff of 3 cycles expires.
REQ-038 err_core[2] pulsed for 1 cycle, all crypt_ready=1, rr_ptr=2 -> core 2 is skipped for all later packets and core 3 is chosen.
REQ-039 MAX_WORDS=16, 17-word packet without in_last -> 16 wr_en pulses, then err_pkt=1, in_ready=0, and no further wr_en.
REQ-040 rst asserted after 3 words of a 5-word packet -> wr_en=0 and in_ready=0 immediately; after release, the next packet goes to core 0.
REQ-041 in_valid toggling 1,0,1 within a packet -> wr_en pulses only in cycles following acceptance, and sel does not change between words.

Source files
------------

// File: rtl/core_input_dispatch.sv
// core_input_dispatch
// Accepts packets from a single upstream word stream and broadcasts each word
// to a bank of cores. The target core is chosen round-robin among cores that
// are ready, are not cooling down after their previous packet and have never
// reported an error. Overlength packets lock the block in ERROR until reset.

module core_input_dispatch #(
    parameter int N_CORES   = 4,
    parameter int DIN_WIDTH = 8,
    parameter int MAX_WORDS = 16,
    parameter int HOLDOFF   = 3
) (
    input  logic                 CORE_CLK,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] in_data,
    input  logic [2:0]           in_addr,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CORES-1:0]   crypt_ready,
    input  logic [N_CORES-1:0]   core_idle,
    input  logic [N_CORES-1:0]   err_core,
    output logic [DIN_WIDTH-1:0] din,
    output logic [2:0]           addr_in,
    output logic [N_CORES-1:0]   wr_en,
    output logic                 all_idle,
    output logic                 err_pkt
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [2:0]       HOLD_LOAD = 3'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WORDS);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_CORES - 1);

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        SEND   = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [PTR_W-1:0]       sel_r;
    logic [2:0]             holdoff_r [N_CORES];
    logic [N_CORES-1:0]     err_mask_r;
    logic [CNT_W-1:0]       word_cnt_r;
    logic [DIN_WIDTH-1:0]   din_r;
    logic [2:0]             addr_r;
    logic [N_CORES-1:0]     wr_en_r;
    logic                   in_ready_r;
    logic                   err_pkt_r;

    logic [N_CORES-1:0]     eligible_s;
    logic                   found_hi_s;
    logic [PTR_W-1:0]       idx_hi_s;
    logic [PTR_W-1:0]       idx_lo_s;
    logic                   pick_found_s;
    logic [PTR_W-1:0]       pick_idx_s;
    logic                   accept_s;
    logic                   overlength_s;
    logic                   last_accept_s;
    logic [PTR_W-1:0]       next_ptr_s;
    logic                   all_idle_s;

    // One-hot write strobe for the selected core.
    function automatic logic [N_CORES-1:0] onehot_f(input logic [PTR_W-1:0] idx);
        logic [N_CORES-1:0] v;
        v = {N_CORES{1'b0}};
        for (int i = 0; i < N_CORES; i++) begin
            v[i] = (idx == PTR_W'(i));
        end
        return v;
    endfunction

    // A core may take a new packet only if ready, not cooling down and not faulted.
    always_comb begin
        eligible_s = {N_CORES{1'b0}};
        for (int i = 0; i < N_CORES; i++) begin
            eligible_s[i] = crypt_ready[i] & (holdoff_r[i] == 3'd0) & ~err_mask_r[i];
        end
    end

    // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest overall.
    always_comb begin
        found_hi_s = 1'b0;
        idx_hi_s   = {PTR_W{1'b0}};
        idx_lo_s   = {PTR_W{1'b0}};
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                idx_lo_s = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr_r) begin
                    found_hi_s = 1'b1;
                    idx_hi_s   = PTR_W'(i);
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                idx_lo_s = idx_lo_s;
            end
        end
        pick_found_s = |eligible_s;
        if (found_hi_s) begin
            pick_idx_s = idx_hi_s;
        end else begin
            pick_idx_s = idx_lo_s;
        end
    end

    // Handshake decode; in_ready_r is only ever high while in SEND.
    always_comb begin
        accept_s      = in_valid & in_ready_r;
        overlength_s  = accept_s & ~in_last & (word_cnt_r == CNT_MAX);
        last_accept_s = accept_s & in_last;
        if (sel_r == PTR_LAST) begin
            next_ptr_s = {PTR_W{1'b0}};
        end else begin
            next_ptr_s = sel_r + PTR_W'(1);
        end
    end

    // Main dispatch FSM with registered broadcast outputs.
    always_ff @(posedge CORE_CLK or posedge rst) begin
        if (rst) begin
            state_r    <= SELECT;
            rr_ptr_r   <= {PTR_W{1'b0}};
            sel_r      <= {PTR_W{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
            din_r      <= {DIN_WIDTH{1'b0}};
            addr_r     <= 3'd0;
            wr_en_r    <= {N_CORES{1'b0}};
            in_ready_r <= 1'b0;
            err_pkt_r  <= 1'b0;
        end else begin
            wr_en_r <= {N_CORES{1'b0}};
            case (state_r)
                SELECT: begin
                    if (in_valid && pick_found_s) begin
                        sel_r      <= pick_idx_s;
                        word_cnt_r <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b1;
                        state_r    <= SEND;
                    end else begin
                        in_ready_r <= 1'b0;
                    end
                end
                SEND: begin
                    if (overlength_s) begin
                        err_pkt_r  <= 1'b1;
                        in_ready_r <= 1'b0;
                        state_r    <= ERROR;
                    end else if (accept_s) begin
                        din_r   <= in_data;
                        addr_r  <= in_addr;
                        wr_en_r <= onehot_f(sel_r);
                        if (in_last) begin
                            word_cnt_r <= {CNT_W{1'b0}};
                            rr_ptr_r   <= next_ptr_s;
                            in_ready_r <= 1'b0;
                            state_r    <= SELECT;
                        end else begin
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ERROR: begin
                    in_ready_r <= 1'b0;
                end
                default: begin
                    in_ready_r <= 1'b0;
                    state_r    <= SELECT;
                end
            endcase
        end
    end

    // Per-core cool-down: reload on a packet's last word, otherwise count down.
    always_ff @(posedge CORE_CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CORES; i++) begin
                holdoff_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (last_accept_s && (sel_r == PTR_W'(i))) begin
                    holdoff_r[i] <= HOLD_LOAD;
                end else if (holdoff_r[i] != 3'd0) begin
                    holdoff_r[i] <= holdoff_r[i] - 3'd1;
                end else begin
                    holdoff_r[i] <= 3'd0;
                end
            end
        end
    end

    // Faulted cores are excluded permanently until reset.
    always_ff @(posedge CORE_CLK or posedge rst) begin
        if (rst) begin
            err_mask_r <= {N_CORES{1'b0}};
        end else begin
            err_mask_r <= err_mask_r | err_core;
        end
    end

    // Quiescence indicator: nothing pending upstream or in flight, live cores idle.
    always_comb begin
        all_idle_s = (state_r == SELECT) & ~in_valid & ~(|wr_en_r) & (&(core_idle | err_mask_r));
    end

    assign in_ready = in_ready_r;
    assign din      = din_r;
    assign addr_in  = addr_r;
    assign wr_en    = wr_en_r;
    assign err_pkt  = err_pkt_r;
    assign all_idle = all_idle_s;

endmodule

// File: tb/tb_core_input_dispatch.sv
// Self-checking bench for core_input_dispatch: a behavioural packet-level
// model predicts every output each cycle, plus literal sequence checks.

module tb_core_input_dispatch;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXW = 16;
    localparam int HOLD = 3;

    logic         CORE_CLK = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic [2:0]   in_addr = '0;
    logic         in_last = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] crypt_ready = '1;
    logic [N-1:0] core_idle = '1;
    logic [N-1:0] err_core = '0;
    logic [W-1:0] din;
    logic [2:0]   addr_in;
    logic [N-1:0] wr_en;
    logic         all_idle;
    logic         err_pkt;

    core_input_dispatch #(
        .N_CORES(N), .DIN_WIDTH(W), .MAX_WORDS(MAXW), .HOLDOFF(HOLD)
    ) dut (
        .CORE_CLK(CORE_CLK), .rst(rst), .in_data(in_data), .in_addr(in_addr),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .crypt_ready(crypt_ready), .core_idle(core_idle), .err_core(err_core),
        .din(din), .addr_in(addr_in), .wr_en(wr_en), .all_idle(all_idle),
        .err_pkt(err_pkt)
    );

    always #5 CORE_CLK = ~CORE_CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit started = 1'b0;
    int wr_log[$];
    int wr_cyc[$];

    // Model state: 0 = choosing a core, 1 = streaming a packet, 2 = locked up.
    int           m_state;
    int           m_rr;
    int           m_sel;
    int           m_cnt;
    int           m_hold[N];
    logic [N-1:0] m_mask;
    logic [N-1:0] m_wr;
    logic [W-1:0] m_din;
    logic [2:0]   m_addr;
    logic         m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CORE_CLK) cyc <= cyc + 1;

    // Behavioural model, advanced on every clock edge from the sampled inputs.
    always @(posedge CORE_CLK or posedge rst) begin
        if (rst) begin
            m_state = 0; m_rr = 0; m_sel = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) m_hold[i] = 0;
            m_mask = '0; m_wr = '0; m_din = '0; m_addr = '0; m_err = 1'b0;
        end else begin : step
            int pick;
            int load_core;
            logic [N-1:0] nwr;
            pick = -1;
            load_core = -1;
            nwr = '0;
            if (m_state == 0 && in_valid) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (pick < 0 && crypt_ready[c] && m_hold[c] == 0 && !m_mask[c]) pick = c;
                end
                if (pick >= 0) begin
                    m_sel = pick; m_cnt = 0; m_state = 1;
                end
            end else if (m_state == 1 && in_valid) begin
                if (!in_last && m_cnt == MAXW) begin
                    m_err = 1'b1; m_state = 2;
                end else begin
                    nwr[m_sel] = 1'b1;
                    m_din = in_data; m_addr = in_addr;
                    m_cnt++;
                    if (in_last) begin
                        load_core = m_sel;
                        m_rr = (m_sel + 1) % N;
                        m_cnt = 0;
                        m_state = 0;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (m_hold[i] > 0) m_hold[i]--;
                if (i == load_core) m_hold[i] = HOLD;
            end
            m_mask = m_mask | err_core;
            m_wr = nwr;
        end
    end

    // Per-cycle comparison against the model, plus a log of write strobes.
    always @(negedge CORE_CLK) begin
        if (started && !rst) begin
            check("wr_en", wr_en, m_wr);
            check("din", din, m_din);
            check("addr_in", addr_in, m_addr);
            check("in_ready", in_ready, (m_state == 1));
            check("err_pkt", err_pkt, m_err);
            check("all_idle", all_idle,
                  (m_state == 0) && !in_valid && (m_wr == '0) && (&(core_idle | m_mask)));
            if (wr_en != '0) begin
                wr_log.push_back(int'(wr_en));
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic send_word(input logic [W-1:0] d, input logic [2:0] a, input logic l);
        bit got;
        int guard;
        got = 1'b0;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_addr = a; in_last = l;
        while (!got && guard < 50) begin
            @(negedge CORE_CLK);
            got = in_ready;
            @(posedge CORE_CLK);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_pkt(input int nwords, input int base);
        for (int i = 0; i < nwords; i++) begin
            send_word(W'(base + i), 3'(base + i), (i == nwords - 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge CORE_CLK);
        @(posedge CORE_CLK);
        #1;
        check("rst_wr_en", wr_en, 32'd0);
        check("rst_in_ready", in_ready, 32'd0);
        check("rst_err_pkt", err_pkt, 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_addr_in", addr_in, 32'd0);
        rst = 1'b0;
        started = 1'b1;
        wr_log.delete();
        wr_cyc.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CORE_CLK);
            #1;
        end
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, "_len"}, wr_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < wr_log.size()) check(name, wr_log[i], exp[i]);
        end
    endtask

    initial begin
        // Round-robin over fully ready cores, 2-word packets.
        crypt_ready = 4'b1111; core_idle = 4'b1111; err_core = 4'b0000;
        do_reset();
        @(negedge CORE_CLK);
        check("idle_after_reset", all_idle, 32'd1);
        @(posedge CORE_CLK); #1;
        send_pkt(2, 8'h10);
        send_pkt(2, 8'h20);
        send_pkt(2, 8'h30);
        idle_cycles(2);
        check_log("rr_basic", '{1, 1, 2, 2, 4, 4});

        // Partial readiness with holdoff on core 1.
        crypt_ready = 4'b1010;
        do_reset();
        send_pkt(2, 8'h40);
        send_pkt(2, 8'h50);
        send_pkt(2, 8'h60);
        idle_cycles(2);
        check_log("rr_partial", '{2, 2, 8, 8, 2, 2});

        // Only core 1 ready: the second packet waits out the holdoff.
        crypt_ready = 4'b0010;
        do_reset();
        send_pkt(1, 8'h70);
        send_pkt(1, 8'h71);
        idle_cycles(2);
        check_log("holdoff_seq", '{2, 2});
        if (wr_cyc.size() == 2) check("holdoff_gap", wr_cyc[1] - wr_cyc[0], HOLD + 2);
        else check("holdoff_gap_len", wr_cyc.size(), 32'd2);

        // Core 2 faults while rr_ptr points at it; it is skipped from then on.
        crypt_ready = 4'b1111;
        do_reset();
        send_pkt(1, 8'h80);
        send_pkt(1, 8'h81);
        err_core = 4'b0100;
        @(posedge CORE_CLK); #1;
        err_core = 4'b0000;
        core_idle = 4'b1011;
        @(negedge CORE_CLK);
        check("idle_masked_core", all_idle, 32'd1);
        @(posedge CORE_CLK); #1;
        for (int p = 0; p < 4; p++) send_pkt(1, 8'h90 + p);
        idle_cycles(2);
        check_log("err_skip", '{1, 2, 8, 1, 2, 8});
        core_idle = 4'b1111;

        // Overlength packet: 16 forwarded, 17th triggers the error lock.
        do_reset();
        for (int i = 0; i < MAXW + 1; i++) send_word(W'(8'hA0 + i), 3'(i), 1'b0);
        in_valid = 1'b1;
        idle_cycles(5);
        in_valid = 1'b0;
        idle_cycles(1);
        check("ovl_pulses", wr_log.size(), MAXW);
        check("ovl_err_pkt", err_pkt, 32'd1);
        check("ovl_in_ready", in_ready, 32'd0);

        // Reset in the middle of a packet kills it immediately.
        do_reset();
        for (int i = 0; i < 3; i++) send_word(W'(8'hC0 + i), 3'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", wr_en, 32'd0);
        check("midrst_in_ready", in_ready, 32'd0);
        do_reset();
        send_pkt(1, 8'hD0);
        // Gapped packet: valid drops between words, same core keeps the packet.
        send_word(8'hE1, 3'd5, 1'b0);
        idle_cycles(2);
        send_word(8'hE2, 3'd6, 1'b1);
        idle_cycles(2);
        check_log("post_rst_gap", '{1, 2, 2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
